// File: rtl/spi_programmer.sv
// SPI mode-0 slave that loads 32-bit words into MRAM through the programmer port.
// All SPI inputs are oversampled in the clk domain; sck must stay high/low >= 3 clk periods.
module spi_programmer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter logic [7:0]  CMD_WRITE   = 8'hA5,
    parameter logic [7:0]  CMD_ENTER   = 8'hC3,
    parameter logic [7:0]  CMD_EXIT    = 8'h3C
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              sdi,
    input  logic              cs_n,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pdata,
    output logic              pwe,
    output logic              prog_mode,
    output logic              frame_err,
    output logic [15:0]       wcount
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, WRITE, SKIP} state_t;

    localparam logic [5:0] CMD_LAST  = 6'd7;
    localparam logic [5:0] ADDR_LAST = 6'(ADDR_W - 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, csn_sync_q;
    logic                   sck_prev_q;
    state_t                 state_q;
    logic [5:0]             bit_cnt_q;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [ADDR_W-1:0]      addr_q, paddr_q;
    logic [DATA_W-1:0]      pdata_q;
    logic                   pwe_q, prog_mode_q, frame_err_q;
    logic [15:0]            wcount_q;
    logic                   sck_s, sdi_s, csn_s, sck_rise;

    always_comb begin
        sck_s    = sck_sync_q[SYNC_STAGES-1];
        sdi_s    = sdi_sync_q[SYNC_STAGES-1];
        csn_s    = csn_sync_q[SYNC_STAGES-1];
        sck_rise = sck_s & ~sck_prev_q;
        shift_d  = {shift_q[DATA_W-2:0], sdi_s};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_sync_q  <= '0;
            sdi_sync_q  <= '0;
            csn_sync_q  <= '1;
            sck_prev_q  <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            paddr_q     <= '0;
            pdata_q     <= '0;
            pwe_q       <= 1'b0;
            prog_mode_q <= 1'b0;
            frame_err_q <= 1'b0;
            wcount_q    <= '0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            csn_sync_q <= {csn_sync_q[SYNC_STAGES-2:0], cs_n};
            sck_prev_q <= sck_s;
            pwe_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    bit_cnt_q <= '0;
                    if (!csn_s) state_q <= CMD;
                end
                // A deselect is checked before the sck edge, so a coincident bit is dropped.
                CMD: begin
                    if (csn_s) begin
                        if (bit_cnt_q != '0) frame_err_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (sck_rise) begin
                        shift_q <= shift_d;
                        if (bit_cnt_q == CMD_LAST) begin
                            bit_cnt_q <= '0;
                            case (shift_d[7:0])
                                CMD_WRITE: begin
                                    if (prog_mode_q) begin
                                        state_q <= ADDR;
                                    end else begin
                                        frame_err_q <= 1'b1;
                                        state_q     <= SKIP;
                                    end
                                end
                                CMD_ENTER: begin
                                    prog_mode_q <= 1'b1;
                                    wcount_q    <= '0;
                                    frame_err_q <= 1'b0;
                                end
                                CMD_EXIT: prog_mode_q <= 1'b0;
                                default: begin
                                    frame_err_q <= 1'b1;
                                    state_q     <= SKIP;
                                end
                            endcase
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end
                end
                ADDR: begin
                    if (csn_s) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (sck_rise) begin
                        shift_q <= shift_d;
                        if (bit_cnt_q == ADDR_LAST) begin
                            addr_q    <= shift_d[ADDR_W-1:0];
                            bit_cnt_q <= '0;
                            state_q   <= DATA;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end
                end
                DATA: begin
                    if (csn_s) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (sck_rise) begin
                        shift_q <= shift_d;
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= WRITE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end
                end
                WRITE: begin
                    paddr_q  <= addr_q;
                    pdata_q  <= shift_q;
                    pwe_q    <= 1'b1;
                    wcount_q <= wcount_q + 16'd1;
                    state_q  <= CMD;
                end
                SKIP: begin
                    if (csn_s) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign paddr     = paddr_q;
    assign pdata     = pdata_q;
    assign pwe       = pwe_q;
    assign prog_mode = prog_mode_q;
    assign frame_err = frame_err_q;
    assign wcount    = wcount_q;

endmodule

// File: tb/tb_spi_programmer.sv
// Directed bench for spi_programmer: hand-written reset/streaming sequences, then a
// table of single-cs_n transactions with hand-computed expected outputs.
module tb_spi_programmer;

    logic        clk = 1'b0;
    logic        reset, sck, sdi, cs_n;
    logic [15:0] paddr;
    logic [31:0] pdata;
    logic        pwe, prog_mode, frame_err;
    logic [15:0] wcount;

    spi_programmer #(
        .SYNC_STAGES(2),
        .ADDR_W(16),
        .DATA_W(32),
        .CMD_WRITE(8'hA5),
        .CMD_ENTER(8'hC3),
        .CMD_EXIT(8'h3C)
    ) dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n),
        .paddr(paddr), .pdata(pdata), .pwe(pwe), .prog_mode(prog_mode),
        .frame_err(frame_err), .wcount(wcount)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int consec   = 0;
    logic pwe_prev = 1'b0;
    logic [15:0] log_a[$];
    logic [31:0] log_d[$];

    always @(negedge clk) begin
        if (pwe === 1'b1) begin
            pulses++;
            log_a.push_back(paddr);
            log_d.push_back(pdata);
            if (pwe_prev) consec++;
        end
        pwe_prev = (pwe === 1'b1);
    end

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] addr;
        logic [31:0] data;
        int          nbits;
        int          exp_pulses;
        logic        exp_pm;
        logic        exp_err;
        logic [15:0] exp_wc;
        logic [15:0] exp_paddr;
        logic [31:0] exp_pdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [55:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            sdi = v[55-i];
            clks(4);
            sck = 1'b1;
            clks(4);
            sck = 1'b0;
        end
    endtask

    initial begin
        int base;
        vecs[0] = '{8'h3C, 16'h0000, 32'h0,        8,  0, 1'b0, 1'b0, 16'd3, 16'h0002, 32'h3};
        vecs[1] = '{8'hA5, 16'h0010, 32'h11111111, 56, 0, 1'b0, 1'b1, 16'd3, 16'h0002, 32'h3};
        vecs[2] = '{8'hC3, 16'h0000, 32'h0,        8,  0, 1'b1, 1'b0, 16'd0, 16'h0002, 32'h3};
        vecs[3] = '{8'hA5, 16'h1234, 32'h89ABCDEF, 28, 0, 1'b1, 1'b1, 16'd0, 16'h0002, 32'h3};
        vecs[4] = '{8'hA5, 16'h00FF, 32'hCAFEF00D, 56, 1, 1'b1, 1'b1, 16'd1, 16'h00FF, 32'hCAFEF00D};
        vecs[5] = '{8'h00, 16'h0000, 32'h0,        8,  0, 1'b1, 1'b1, 16'd1, 16'h00FF, 32'hCAFEF00D};
        vecs[6] = '{8'h3C, 16'h0000, 32'h0,        8,  0, 1'b0, 1'b1, 16'd1, 16'h00FF, 32'hCAFEF00D};
        vecs[7] = '{8'hC3, 16'h0000, 32'h0,        8,  0, 1'b1, 1'b0, 16'd0, 16'h00FF, 32'hCAFEF00D};
        vecs[8] = '{8'hA5, 16'hFFFF, 32'h00000000, 56, 1, 1'b1, 1'b0, 16'd1, 16'hFFFF, 32'h00000000};

        reset = 1'b0; cs_n = 1'b0; sck = 1'b0; sdi = 1'b0;
        clks(2);
        for (int i = 0; i < 8; i++) begin
            sdi = i[0];
            clks(3);
            sck = 1'b1;
            clks(3);
            sck = 1'b0;
        end
        chk("rst_paddr", 32'(paddr), 32'h0);
        chk("rst_pdata", pdata, 32'h0);
        chk("rst_pm", 32'(prog_mode), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        chk("rst_wcount", 32'(wcount), 32'h0);
        chk("rst_pulses", 32'(pulses), 32'h0);
        cs_n = 1'b1;
        clks(2);
        reset = 1'b1;
        clks(6);

        // Reset in the middle of a write frame must not emit a write.
        cs_n = 1'b0;
        clks(4);
        send_bits({8'hC3, 48'h0}, 8);
        clks(2);
        chk("mid_pm_set", 32'(prog_mode), 32'h1);
        send_bits({8'hA5, 16'h0001, 32'h55555555}, 30);
        reset = 1'b0;
        clks(3);
        chk("mid_pm_clr", 32'(prog_mode), 32'h0);
        cs_n = 1'b1;
        clks(3);
        reset = 1'b1;
        clks(6);
        chk("mid_pulses", 32'(pulses), 32'h0);

        // ENTER then one WRITE under a single cs_n.
        base = pulses;
        cs_n = 1'b0;
        clks(4);
        send_bits({8'hC3, 48'h0}, 8);
        clks(2);
        chk("ew_pm", 32'(prog_mode), 32'h1);
        send_bits({8'hA5, 16'h0004, 32'hDEADBEEF}, 56);
        clks(4);
        cs_n = 1'b1;
        clks(10);
        chk("ew_pulses", 32'(pulses - base), 32'h1);
        chk("ew_paddr", 32'(paddr), 32'h0004);
        chk("ew_pdata", pdata, 32'hDEADBEEF);
        chk("ew_wcount", 32'(wcount), 32'h1);
        chk("ew_err", 32'(frame_err), 32'h0);
        if (log_a.size() > base) begin
            chk("ew_pulse_addr", 32'(log_a[base]), 32'h0004);
            chk("ew_pulse_data", log_d[base], 32'hDEADBEEF);
        end

        // ENTER plus three streamed writes under one cs_n.
        base = pulses;
        cs_n = 1'b0;
        clks(4);
        send_bits({8'hC3, 48'h0}, 8);
        for (int k = 0; k < 3; k++)
            send_bits({8'hA5, 16'(k), 32'(k + 1)}, 56);
        clks(4);
        cs_n = 1'b1;
        clks(10);
        chk("bb_pulses", 32'(pulses - base), 32'h3);
        chk("bb_wcount", 32'(wcount), 32'h3);
        chk("bb_paddr", 32'(paddr), 32'h2);
        chk("bb_pdata", pdata, 32'h3);
        chk("bb_err", 32'(frame_err), 32'h0);
        for (int k = 0; k < 3; k++) begin
            if (log_a.size() > base + k) begin
                chk($sformatf("bb_addr%0d", k), 32'(log_a[base+k]), 32'(k));
                chk($sformatf("bb_data%0d", k), log_d[base+k], 32'(k + 1));
            end else begin
                chk($sformatf("bb_present%0d", k), 32'(log_a.size()), 32'(base + k + 1));
            end
        end

        for (int i = 0; i < 9; i++) begin
            base = pulses;
            cs_n = 1'b0;
            clks(4);
            send_bits({vecs[i].cmd, vecs[i].addr, vecs[i].data}, vecs[i].nbits);
            clks(4);
            cs_n = 1'b1;
            clks(10);
            chk($sformatf("v%0d_pulses", i), 32'(pulses - base), 32'(vecs[i].exp_pulses));
            chk($sformatf("v%0d_pm", i), 32'(prog_mode), 32'(vecs[i].exp_pm));
            chk($sformatf("v%0d_err", i), 32'(frame_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_wcount", i), 32'(wcount), 32'(vecs[i].exp_wc));
            chk($sformatf("v%0d_paddr", i), 32'(paddr), 32'(vecs[i].exp_paddr));
            chk($sformatf("v%0d_pdata", i), pdata, vecs[i].exp_pdata);
        end

        chk("pwe_consecutive", 32'(consec), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
